branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight branch queue entries; power of two, 2..16.
REQ-002 SHALL have ports (clock and reset first):
  i_saat  input  1  clock; all state updates on rising edge
  i_reset_n  input  1  synchronous, active-low reset
  i_ongoru_gecerli  input  1  fetch pushes a predicted branch
  i_buyruk_sayaci  input  32  PC of pushed branch
  i_buyruk_ongoru  input  1  pushed prediction (1 taken, 0 not taken)
  o_ongoru_hazir  output  1  queue can accept a push this cycle
  i_sonuc_gecerli  input  1  execute presents outcome of oldest branch
  i_buyruk_atladi  input  1  actual outcome (1 taken)
  i_sonuc_hedef  input  32  actual taken target
  o_guncelle_gecerli  output  1  one-cycle update pulse to predictor
  o_guncelle_sayaci  output  32  PC of resolved branch
  o_buyruk_atladi  output  1  actual outcome of resolved branch
  o_ongoru_yanlis  output  1  resolved branch was mispredicted
  o_yonlendir_adres  output  32  fetch redirect PC, valid with o_ongoru_yanlis
  o_bos  output  1  queue empty
REQ-003 SHALL use one clock only; reset synchronous, active-low, as stated.

Function
REQ-004 SHALL hold an in-order FIFO of {PC, prediction}; read/write pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-005 SHALL accept a push when i_ongoru_gecerli && o_ongoru_hazir; o_ongoru_hazir = (count < DEPTH) && state != FLUSH, independent of same-cycle resolve.
REQ-006 SHALL apply i_sonuc_gecerli only to the oldest entry stored before the current cycle; ignored when queue empty or in FLUSH (no update pulse, no state change).
REQ-007 SHALL register outputs: o_guncelle_gecerli pulses exactly one cycle, the cycle after an accepted resolve, with o_guncelle_sayaci = entry PC, o_buyruk_atladi = i_buyruk_atladi.
REQ-008 SHALL assert o_ongoru_yanlis with that pulse iff stored prediction != i_buyruk_atladi; otherwise 0.
REQ-009 SHALL set o_yonlendir_adres = i_sonuc_hedef if actual taken, else entry PC + 4 (modulo 2^32, wraps at 0xFFFFFFFC -> 0x00000000); holds 0 when no mispredict pulse.
REQ-010 SHALL implement states EMPTY, ACTIVE, FLUSH: EMPTY->ACTIVE on push; ACTIVE->EMPTY when last entry resolved correctly with no same-cycle push; ACTIVE->FLUSH on mispredict; FLUSH->EMPTY after exactly one cycle.
REQ-011 SHALL on mispredict discard all younger entries, including any push accepted in the same cycle; queue empty and o_bos=1 in the FLUSH cycle.
REQ-012 SHALL on simultaneous correct resolve and push keep count unchanged (full queue stays full; o_ongoru_hazir stays 0 that cycle).
REQ-013 SHALL drive o_bos = (count == 0), registered.

Reset
REQ-014 SHALL, when i_reset_n=0 at a rising edge, set state EMPTY, pointers and count 0, o_bos=1, o_ongoru_hazir=1 after reset, all other outputs 0.
REQ-015 SHALL, on reset mid-operation, drop all queued entries and any pending update pulse; no pulse in the cycle after reset.

Configuration
REQ-016 SHALL, with BRANCH_RESOLVER_STATS_EN defined, add outputs o_cozulen_sayisi (16) and o_yanlis_sayisi (16), counting accepted resolves and mispredicts, saturating at 0xFFFF, cleared by reset.
REQ-017 SHALL, without BRANCH_RESOLVER_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-018 Reset: i_reset_n=0 two cycles -> o_bos=1, o_ongoru_hazir=1, o_guncelle_gecerli=0, o_yonlendir_adres=0.
REQ-019 Correct resolve: push PC=0x00, pred=1; next cycle resolve taken, target 0x40 -> one cycle later pulse, sayaci=0x00, atladi=1, yanlis=0; o_bos=1.
REQ-020 Mispredict: push PCs 0x00,0x04,0x08 pred=0; resolve oldest taken, target 0x100 -> yanlis=1, yonlendir=0x100, FLUSH one cycle, o_bos=1, no further pulses for 0x04/0x08.
REQ-021 Not-taken mispredict at wrap: push PC=0xFFFFFFFC pred=1; resolve not taken -> yonlendir=0x00000000, yanlis=1.
REQ-022 Full/simultaneous: fill DEPTH=4 entries -> o_ongoru_hazir=0; push ignored; resolve correct + push same cycle -> count stays 4, FIFO order preserved on subsequent resolves.
REQ-023 Empty resolve: i_sonuc_gecerli=1 with queue empty -> no pulse; with STATS_EN, o_cozulen_sayisi unchanged.

Source files
------------

// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver_if
// Description : Fetch/execute/predictor bundle for branch_resolver.
//               Stats outputs exist only with BRANCH_RESOLVER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolver_if;
    logic        i_ongoru_gecerli;
    logic [31:0] i_buyruk_sayaci;
    logic        i_buyruk_ongoru;
    logic        o_ongoru_hazir;
    logic        i_sonuc_gecerli;
    logic        i_buyruk_atladi;
    logic [31:0] i_sonuc_hedef;
    logic        o_guncelle_gecerli;
    logic [31:0] o_guncelle_sayaci;
    logic        o_buyruk_atladi;
    logic        o_ongoru_yanlis;
    logic [31:0] o_yonlendir_adres;
    logic        o_bos;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] o_cozulen_sayisi;
    logic [15:0] o_yanlis_sayisi;
`endif

    modport master (
        output i_ongoru_gecerli, i_buyruk_sayaci, i_buyruk_ongoru,
        output i_sonuc_gecerli, i_buyruk_atladi, i_sonuc_hedef,
        input  o_ongoru_hazir, o_guncelle_gecerli, o_guncelle_sayaci,
        input  o_buyruk_atladi, o_ongoru_yanlis, o_yonlendir_adres, o_bos
`ifdef BRANCH_RESOLVER_STATS_EN
        , input o_cozulen_sayisi, o_yanlis_sayisi
`endif
    );

    modport slave (
        input  i_ongoru_gecerli, i_buyruk_sayaci, i_buyruk_ongoru,
        input  i_sonuc_gecerli, i_buyruk_atladi, i_sonuc_hedef,
        output o_ongoru_hazir, o_guncelle_gecerli, o_guncelle_sayaci,
        output o_buyruk_atladi, o_ongoru_yanlis, o_yonlendir_adres, o_bos
`ifdef BRANCH_RESOLVER_STATS_EN
        , output o_cozulen_sayisi, o_yanlis_sayisi
`endif
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolver
// Description : In-order queue of predicted branches; compares outcomes,
//               pulses predictor updates and redirects fetch on mispredict.
//               Optional counters via BRANCH_RESOLVER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int DEPTH = 4
) (
    input  wire logic         i_saat,
    input  wire logic         i_reset_n,
    branch_resolver_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_EMPTY  = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_FLUSH  = 2'd2;

    logic [31:0]      r_pc   [DEPTH];
    logic             r_pred [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_state;
    logic             r_bos;
    logic             r_upd_valid, r_atladi, r_yanlis;
    logic [31:0]      r_upd_pc, r_yonlendir;

    logic [31:0]      w_rd_pc;
    logic             w_rd_pred, w_hazir, w_res_acc, w_mis, w_res_ok, w_push_acc;
    logic [CNT_W-1:0] w_count_nxt;

    always_comb begin
        w_rd_pc    = r_pc[r_rd_ptr];
        w_rd_pred  = r_pred[r_rd_ptr];
        w_hazir    = (r_count < c_DEPTH_CNT) && (r_state != c_ST_FLUSH);
        w_res_acc  = bus.i_sonuc_gecerli && (r_count != '0) && (r_state != c_ST_FLUSH);
        w_mis      = w_res_acc && (w_rd_pred != bus.i_buyruk_atladi);
        w_res_ok   = w_res_acc && !w_mis;
        // A full queue still takes a push that lands with a correct resolve,
        // reusing the slot being retired so occupancy stays at DEPTH.
        w_push_acc = bus.i_ongoru_gecerli &&
                     (w_hazir || ((r_count == c_DEPTH_CNT) && w_res_ok));
        w_count_nxt = r_count;
        if (w_mis)
            w_count_nxt = '0;
        else if (w_push_acc && !w_res_ok)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push_acc && w_res_ok)
            w_count_nxt = r_count - 1'b1;
    end

    // Entry storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge i_saat) begin
        if (w_push_acc && !w_mis) begin
            r_pc[r_wr_ptr]   <= bus.i_buyruk_sayaci;
            r_pred[r_wr_ptr] <= bus.i_buyruk_ongoru;
        end
    end

    always_ff @(posedge i_saat) begin
        if (!i_reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_state     <= c_ST_EMPTY;
            r_bos       <= 1'b1;
            r_upd_valid <= 1'b0;
            r_upd_pc    <= '0;
            r_atladi    <= 1'b0;
            r_yanlis    <= 1'b0;
            r_yonlendir <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_bos   <= (w_count_nxt == '0);
            if (w_mis) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_wr_ptr <= r_rd_ptr + 1'b1;
                r_state  <= c_ST_FLUSH;
            end else begin
                if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_res_ok)   r_rd_ptr <= r_rd_ptr + 1'b1;
                case (r_state)
                    c_ST_EMPTY:  if (w_push_acc) r_state <= c_ST_ACTIVE;
                    c_ST_ACTIVE: if (w_count_nxt == '0) r_state <= c_ST_EMPTY;
                    default:     r_state <= c_ST_EMPTY;
                endcase
            end
            r_upd_valid <= w_res_acc;
            r_upd_pc    <= w_res_acc ? w_rd_pc : 32'd0;
            r_atladi    <= w_res_acc && bus.i_buyruk_atladi;
            r_yanlis    <= w_mis;
            r_yonlendir <= !w_mis ? 32'd0 :
                           (bus.i_buyruk_atladi ? bus.i_sonuc_hedef : w_rd_pc + 32'd4);
        end
    end

    assign bus.o_ongoru_hazir     = w_hazir;
    assign bus.o_guncelle_gecerli = r_upd_valid;
    assign bus.o_guncelle_sayaci  = r_upd_pc;
    assign bus.o_buyruk_atladi    = r_atladi;
    assign bus.o_ongoru_yanlis    = r_yanlis;
    assign bus.o_yonlendir_adres  = r_yonlendir;
    assign bus.o_bos              = r_bos;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] r_cozulen, r_yanlis_cnt;

    always_ff @(posedge i_saat) begin
        if (!i_reset_n) begin
            r_cozulen    <= '0;
            r_yanlis_cnt <= '0;
        end else begin
            if (w_res_acc && (r_cozulen != 16'hFFFF))
                r_cozulen <= r_cozulen + 16'd1;
            if (w_mis && (r_yanlis_cnt != 16'hFFFF))
                r_yanlis_cnt <= r_yanlis_cnt + 16'd1;
        end
    end

    assign bus.o_cozulen_sayisi = r_cozulen;
    assign bus.o_yanlis_sayisi  = r_yanlis_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolver
// Description : Directed self-checking bench for branch_resolver (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    branch_resolver_if bif ();

    branch_resolver #(.DEPTH(4)) dut (
        .i_saat    (clk),
        .i_reset_n (rst_n),
        .bus       (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bif.i_ongoru_gecerli = 1'b0;
        bif.i_buyruk_sayaci  = 32'd0;
        bif.i_buyruk_ongoru  = 1'b0;
        bif.i_sonuc_gecerli  = 1'b0;
        bif.i_buyruk_atladi  = 1'b0;
        bif.i_sonuc_hedef    = 32'd0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred);
        bif.i_ongoru_gecerli = 1'b1;
        bif.i_buyruk_sayaci  = pc;
        bif.i_buyruk_ongoru  = pred;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] tgt);
        bif.i_sonuc_gecerli = 1'b1;
        bif.i_buyruk_atladi = taken;
        bif.i_sonuc_hedef   = tgt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_bos", 32'(bif.o_bos), 32'd1);
        chk("rst_hazir", 32'(bif.o_ongoru_hazir), 32'd1);
        chk("rst_upd", 32'(bif.o_guncelle_gecerli), 32'd0);
        chk("rst_yon", bif.o_yonlendir_adres, 32'd0);
        rst_n = 1'b1;

        // Correct taken prediction.
        push(32'h0, 1'b1);
        tick();
        idle();
        chk("c_bos_after_push", 32'(bif.o_bos), 32'd0);
        resolve(1'b1, 32'h40);
        tick();
        idle();
        chk("c_upd", 32'(bif.o_guncelle_gecerli), 32'd1);
        chk("c_pc", bif.o_guncelle_sayaci, 32'h0);
        chk("c_atladi", 32'(bif.o_buyruk_atladi), 32'd1);
        chk("c_yanlis", 32'(bif.o_ongoru_yanlis), 32'd0);
        chk("c_yon", bif.o_yonlendir_adres, 32'd0);
        chk("c_bos", 32'(bif.o_bos), 32'd1);
        tick();
        chk("c_pulse_once", 32'(bif.o_guncelle_gecerli), 32'd0);

        // Taken mispredict with a same-cycle push that must be discarded.
        push(32'h0, 1'b0); tick();
        push(32'h4, 1'b0); tick();
        push(32'h8, 1'b0); tick();
        chk("m_hazir_3", 32'(bif.o_ongoru_hazir), 32'd1);
        push(32'hC, 1'b0);
        resolve(1'b1, 32'h100);
        tick();
        idle();
        resolve(1'b0, 32'h0);
        chk("m_upd", 32'(bif.o_guncelle_gecerli), 32'd1);
        chk("m_pc", bif.o_guncelle_sayaci, 32'h0);
        chk("m_yanlis", 32'(bif.o_ongoru_yanlis), 32'd1);
        chk("m_yon", bif.o_yonlendir_adres, 32'h100);
        chk("m_bos_flush", 32'(bif.o_bos), 32'd1);
        chk("m_hazir_flush", 32'(bif.o_ongoru_hazir), 32'd0);
        tick();
        chk("m_no_pulse_flush", 32'(bif.o_guncelle_gecerli), 32'd0);
        chk("m_hazir_after", 32'(bif.o_ongoru_hazir), 32'd1);
        chk("m_yon_cleared", bif.o_yonlendir_adres, 32'd0);
        tick();
        idle();
        chk("e_no_pulse_empty", 32'(bif.o_guncelle_gecerli), 32'd0);
        chk("e_bos", 32'(bif.o_bos), 32'd1);

        // Not-taken mispredict at the top of the address space.
        push(32'hFFFF_FFFC, 1'b1);
        tick();
        idle();
        resolve(1'b0, 32'h1234);
        tick();
        idle();
        chk("w_yanlis", 32'(bif.o_ongoru_yanlis), 32'd1);
        chk("w_yon", bif.o_yonlendir_adres, 32'h0);
        chk("w_pc", bif.o_guncelle_sayaci, 32'hFFFF_FFFC);
        chk("w_atladi", 32'(bif.o_buyruk_atladi), 32'd0);
        tick();

        // Fill, overflow push, then simultaneous correct resolve + push.
        push(32'h10, 1'b1); tick();
        push(32'h14, 1'b1); tick();
        push(32'h18, 1'b1); tick();
        push(32'h1C, 1'b1); tick();
        chk("f_hazir_full", 32'(bif.o_ongoru_hazir), 32'd0);
        push(32'h50, 1'b1); tick();
        chk("f_hazir_still", 32'(bif.o_ongoru_hazir), 32'd0);
        chk("f_no_pulse", 32'(bif.o_guncelle_gecerli), 32'd0);
        push(32'h20, 1'b1);
        resolve(1'b1, 32'h0);
        tick();
        idle();
        chk("f_pc0", bif.o_guncelle_sayaci, 32'h10);
        chk("f_hazir_sim", 32'(bif.o_ongoru_hazir), 32'd0);
        resolve(1'b1, 32'h0); tick();
        chk("f_pc1", bif.o_guncelle_sayaci, 32'h14);
        resolve(1'b1, 32'h0); tick();
        chk("f_pc2", bif.o_guncelle_sayaci, 32'h18);
        resolve(1'b1, 32'h0); tick();
        chk("f_pc3", bif.o_guncelle_sayaci, 32'h1C);
        chk("f_bos_mid", 32'(bif.o_bos), 32'd0);
        resolve(1'b1, 32'h0); tick();
        chk("f_pc4", bif.o_guncelle_sayaci, 32'h20);
        chk("f_yanlis4", 32'(bif.o_ongoru_yanlis), 32'd0);
        chk("f_bos_end", 32'(bif.o_bos), 32'd1);
        idle();
        tick();

        // Reset while a resolve is pending drops the pulse and the queue.
        push(32'h30, 1'b0); tick();
        idle();
        resolve(1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        idle();
        rst_n = 1'b1;
        chk("r_no_pulse", 32'(bif.o_guncelle_gecerli), 32'd0);
        chk("r_bos", 32'(bif.o_bos), 32'd1);
        resolve(1'b0, 32'h0);
        tick();
        idle();
        chk("r_queue_dropped", 32'(bif.o_guncelle_gecerli), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
